psc_trigger_multi: RTL and testbench
====================================

Name: psc_trigger_multi

Overview:
- Multi-channel successor to the single-channel PSC trigger.
- Takes CHANNELS asynchronous EVR trigger inputs and synchronises each one.
- On each rising edge, produces a per-channel programmable-delay, programmable-width pulse toward the power-supply controllers.
- Sits between the EVR trigger outputs and the PSC link drivers; an optional serial frame encoder reports fired channels on one TX line.

Parameters:
- CHANNELS, 4, number of independent trigger channels (1..16).
- CNT_W, 16, bit width of the delay and width counters.
- SYNC_STAGES, 2, flip-flop stages in each evr_trigger synchroniser (min 2).
- BIT_CYCLES, 434, clk cycles per serial bit (optional feature only; min 2).

Ports:
- clk  in  1  system clock, 50 MHz nominal.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global enable; low forces all channels idle.
- evr_trigger  in  CHANNELS  asynchronous trigger inputs from the EVR.
- cfg_delay  in  CHANNELS*CNT_W  per-channel delay in clk cycles; channel i at [i*CNT_W +: CNT_W].
- cfg_width  in  CHANNELS*CNT_W  per-channel pulse width in clk cycles, same packing.
- clear_overrun  in  CHANNELS  per-channel clear of the overrun flag.
- psc_output  out  CHANNELS  trigger pulses to the PSCs.
- busy  out  CHANNELS  high while a channel is in DELAY or PULSE.
- overrun  out  CHANNELS  sticky flag: a trigger edge arrived while the channel was busy.
- tx_output  out  1  serial frame line; idle high.

Behaviour:
- Reset (reset=0, async):
  - All synchroniser flops, counters and flags cleared.
  - psc_output=0, busy=0, overrun=0, tx_output=1.
  - Every channel FSM goes to IDLE.
  - Deassertion takes effect at the next clk edge.
- Synchroniser: evr_trigger[i] passes through SYNC_STAGES flops, then one history flop; edge[i] = sync_out & ~history.
- Per-channel FSM, states IDLE, DELAY, PULSE:
  - IDLE, edge, enable=1:
    - Latch cfg_delay[i] into cnt.
    - If the latched delay is 0, go to PULSE and load cnt with max(cfg_width[i],1).
    - Otherwise go to DELAY.
  - DELAY: decrement cnt each cycle. When cnt=1, go to PULSE and load cnt with max(cfg_width[i],1).
  - PULSE: psc_output[i]=1 (registered). Decrement; when cnt=1, go to IDLE.
- Latency: first clk edge sampling evr_trigger[i]=1 is cycle 0. psc_output[i] rises at cycle SYNC_STAGES+2+D and stays high for max(W,1) cycles.
- cfg_delay/cfg_width are sampled only at edge accept (delay) and at DELAY→PULSE (width). Changes mid-operation have no other effect.
- The width counter uses the full CNT_W bits; the all-ones value gives 2^CNT_W-1 cycles. No wrap.
- Edge while busy[i]=1:
  - The edge is ignored and the running pulse is unaffected.
  - overrun[i] is set.
  - If set and clear_overrun[i] occur in the same cycle, set wins.
- Edge on the last PULSE cycle counts as busy: it is ignored and sets overrun.
- enable=0:
  - All FSMs return to IDLE on the next clk and psc_output=0 (any pulse is truncated).
  - Edges seen while disabled are discarded and do not set overrun.
  - Synchronisers keep running, so a level held high across re-enable does not fire.
- Channels are fully independent; simultaneous edges on several channels all fire with identical latency.

Optional Feature:
- Macro: PSC_TRIGGER_TX_FRAME_EN.
- Defined:
  - Each psc_output[i] rising edge sets pending[i]. If pending[i] is already set, the event is dropped.
  - A round-robin arbiter, starting after the last served channel, selects a pending channel when the transmitter is idle. Its pending bit clears on frame start.
  - Frame format: start bit 0, 8 data bits LSB-first = channel index, stop bit 1. Each bit lasts BIT_CYCLES clocks.
  - Frames are back-to-back with no extra idle.
  - enable=0 aborts the current frame: tx_output=1 next cycle and pending is cleared.
- Undefined: tx_output is tied to 1 and no frame logic is synthesised.

Test Plan:
- Reset low 300 ns then high; hold evr_trigger=0 -> psc_output=0, busy=0, overrun=0, tx_output=1 throughout.
- CHANNELS=4, ch0 delay=10, width=5; evr_trigger[0] rises at cycle 0 -> psc_output[0] high cycles 14..18 only; busy[0] high from cycle 4 through 18.
- ch1 delay=0, width=0; trigger -> psc_output[1] high exactly 1 cycle at cycle 4.
- ch2 delay=100, width=20; second edge at cycle 50 -> only one pulse, overrun[2]=1. Pulse clear_overrun[2] -> overrun[2]=0. Set and clear in the same cycle -> overrun[2] stays 1.
- ch3 delay=50; drop enable at cycle 30 -> psc_output[3] never rises, busy[3]=0 at cycle 31. Re-enable with evr held high -> no pulse.
- With PSC_TRIGGER_TX_FRAME_EN and BIT_CYCLES=4, fire ch1 and ch3 in the same cycle -> frames for 1 then 3:
  - ch1 frame bits: 0,1,0,0,0,0,0,0,0,1.
  - ch3 frame follows immediately, total 80 clk cycles.
  - Assert reset mid-frame -> tx_output=1 immediately.

Source files
------------

// File: rtl/psc_trigger_multi.sv
// psc_trigger_multi: per-channel synchronised EVR trigger -> programmable delay/width PSC pulse.
// Optional serial frame encoder reporting fired channels, enabled by `define PSC_TRIGGER_TX_FRAME_EN.
module psc_trigger_multi #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int BIT_CYCLES  = 434
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CHANNELS-1:0]       evr_trigger,
    input  logic [CHANNELS*CNT_W-1:0] cfg_delay,
    input  logic [CHANNELS*CNT_W-1:0] cfg_width,
    input  logic [CHANNELS-1:0]       clear_overrun,
    output logic [CHANNELS-1:0]       psc_output,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       overrun,
    output logic                      tx_output
);
    typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_hist;
        logic                   r_edge;
        logic                   r_psc;
        logic                   r_busy;
        logic                   r_ovr;
        state_t                 r_state;
        state_t                 w_next;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_cnt_next;
        logic [CNT_W-1:0]       w_delay;
        logic [CNT_W-1:0]       w_wcfg;
        logic [CNT_W-1:0]       w_width;
        logic                   w_over;

        assign w_delay = cfg_delay[c*CNT_W +: CNT_W];
        assign w_wcfg  = cfg_width[c*CNT_W +: CNT_W];
        assign w_width = (w_wcfg == '0) ? CNT_W'(1) : w_wcfg;
        assign w_over  = r_edge && enable && (r_state != IDLE);

        // synchroniser chain, history flop and registered rising-edge strobe
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync <= '0;
                r_hist <= 1'b0;
                r_edge <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], evr_trigger[c]};
                r_hist <= r_sync[SYNC_STAGES-1];
                r_edge <= r_sync[SYNC_STAGES-1] & ~r_hist;
            end
        end

        // next state and counter; disable forces IDLE and drops pending edges
        always_comb begin
            w_next     = r_state;
            w_cnt_next = r_cnt;
            unique case (r_state)
                IDLE: begin
                    if (r_edge) begin
                        w_next     = (w_delay == '0) ? PULSE : DELAY;
                        w_cnt_next = (w_delay == '0) ? w_width : w_delay;
                    end
                end
                DELAY: begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_next     = PULSE;
                        w_cnt_next = w_width;
                    end
                end
                PULSE: begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
            if (!enable) w_next = IDLE;
        end

        // state register, registered outputs and sticky overrun (set beats clear)
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_psc   <= 1'b0;
                r_busy  <= 1'b0;
                r_ovr   <= 1'b0;
            end else begin
                r_state <= w_next;
                r_cnt   <= w_cnt_next;
                r_psc   <= enable && (r_state == PULSE);
                r_busy  <= enable && (r_state != IDLE);
                r_ovr   <= w_over | (r_ovr & ~clear_overrun[c]);
            end
        end

        assign psc_output[c] = r_psc;
        assign busy[c]       = r_busy;
        assign overrun[c]    = r_ovr;
    end

`ifdef PSC_TRIGGER_TX_FRAME_EN
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BC_W = $clog2(BIT_CYCLES);

    logic [CHANNELS-1:0] r_psc_d;
    logic [CHANNELS-1:0] r_pend;
    logic [CHANNELS-1:0] w_rise;
    logic [CH_W-1:0]     r_last;
    logic [CH_W-1:0]     w_sel;
    logic                w_found;
    logic                r_tx_busy;
    logic [3:0]          r_bit_idx;
    logic [BC_W-1:0]     r_bit_cnt;
    logic [9:0]          r_frame;
    logic                w_frame_end;
    logic                w_start;

    assign w_rise      = psc_output & ~r_psc_d;
    assign w_frame_end = r_tx_busy && (r_bit_idx == 4'd9) && (r_bit_cnt == BC_W'(BIT_CYCLES - 1));
    assign w_start     = enable && w_found && (!r_tx_busy || w_frame_end);
    assign tx_output   = r_tx_busy ? r_frame[r_bit_idx] : 1'b1;

    // round-robin pick of the first pending channel after the last one served
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        for (int k = 1; k <= CHANNELS; k++) begin
            if (!w_found && r_pend[CH_W'((int'(r_last) + k) % CHANNELS)]) begin
                w_found = 1'b1;
                w_sel   = CH_W'((int'(r_last) + k) % CHANNELS);
            end
        end
    end

    // pending flags and frame transmitter; back-to-back frames start on the stop bit's last cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_psc_d   <= '0;
            r_pend    <= '0;
            r_last    <= CH_W'(CHANNELS - 1);
            r_tx_busy <= 1'b0;
            r_bit_idx <= '0;
            r_bit_cnt <= '0;
            r_frame   <= '1;
        end else begin
            r_psc_d <= psc_output;
            if (!enable) begin
                r_pend    <= '0;
                r_tx_busy <= 1'b0;
            end else begin
                r_pend <= (r_pend & ~(w_start ? (CHANNELS'(1) << w_sel) : '0)) | w_rise;
                if (w_start) begin
                    r_tx_busy <= 1'b1;
                    r_bit_idx <= '0;
                    r_bit_cnt <= '0;
                    r_last    <= w_sel;
                    r_frame   <= {1'b1, 8'(w_sel), 1'b0};
                end else if (w_frame_end) begin
                    r_tx_busy <= 1'b0;
                end else if (r_tx_busy) begin
                    if (r_bit_cnt == BC_W'(BIT_CYCLES - 1)) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                    end
                end
            end
        end
    end
`else
    // without the frame encoder the line idles high; BIT_CYCLES has no effect
    if (BIT_CYCLES >= 2) begin : g_tx_idle
        assign tx_output = 1'b1;
    end else begin : g_tx_idle_short
        assign tx_output = 1'b1;
    end
`endif
endmodule

// File: tb/tb_psc_trigger_multi.sv
// tb_psc_trigger_multi: scoreboard bench for psc_trigger_multi (pulses and optional TX frames)
module tb_psc_trigger_multi;
    localparam int CH = 4;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b1;
    logic [CH-1:0]    evr_trigger = '0;
    logic [CH-1:0]    clear_overrun = '0;
    logic [CH*CW-1:0] cfg_delay = '0;
    logic [CH*CW-1:0] cfg_width = '0;
    logic [CH-1:0]    psc_output;
    logic [CH-1:0]    busy;
    logic [CH-1:0]    overrun;
    logic             tx_output;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int t;

    typedef struct {int ch; int start; int width;} pulse_t;
    pulse_t exp_q[$];
    typedef struct {logic [9:0] word; int gap;} frame_t;
    frame_t exp_f[$];

    psc_trigger_multi #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(2), .BIT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .evr_trigger(evr_trigger),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .clear_overrun(clear_overrun),
        .psc_output(psc_output), .busy(busy), .overrun(overrun), .tx_output(tx_output)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_cfg(input int c, input int d, input int w);
        cfg_delay[c*CW +: CW] = CW'(d);
        cfg_width[c*CW +: CW] = CW'(w);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " psc_output"}, int'(psc_output), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " overrun"}, int'(overrun), 0);
        chk({tag, " tx_output"}, int'(tx_output), 1);
    endtask

    // pulse monitor: every completed pulse is matched against the oldest expectation for its channel
    logic [CH-1:0] prev = '0;
    int rise_at [CH];
    always @(negedge clk) begin
        int idx;
        for (int c = 0; c < CH; c++) begin
            if (psc_output[c] === 1'b1 && !prev[c]) rise_at[c] = cyc;
            if (psc_output[c] === 1'b0 && prev[c]) begin
                idx = -1;
                for (int j = 0; j < exp_q.size(); j++)
                    if (idx < 0 && exp_q[j].ch == c) idx = j;
                if (idx < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected pulse ch%0d: start %0d width %0d, expected none", c, rise_at[c], cyc - rise_at[c]);
                end else begin
                    chk($sformatf("ch%0d pulse start", c), rise_at[c], exp_q[idx].start);
                    chk($sformatf("ch%0d pulse width", c), cyc - rise_at[c], exp_q[idx].width);
                    exp_q.delete(idx);
                end
            end
        end
        prev = psc_output;
    end

`ifdef PSC_TRIGGER_TX_FRAME_EN
    // frame monitor: samples each bit one cycle into it; frames cut by reset are discarded
    initial begin
        logic [9:0] word;
        int st;
        int last_st;
        bit ab;
        frame_t f;
        last_st = 0;
        forever begin
            @(negedge clk);
            if (reset && tx_output == 1'b0) begin
                st = cyc;
                ab = 1'b0;
                word = '0;
                for (int b = 0; b < 10; b++) begin
                    repeat (b == 0 ? 1 : 4) @(negedge clk);
                    word[b] = tx_output;
                    if (!reset) ab = 1'b1;
                end
                repeat (2) @(negedge clk);
                if (!ab) begin
                    if (exp_f.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected frame: word %b at cycle %0d, expected none", word, st);
                    end else begin
                        f = exp_f.pop_front();
                        chk("frame word", int'(word), int'(f.word));
                        if (f.gap >= 0) chk("frame gap", st - last_st, f.gap);
                    end
                    last_st = st;
                end
            end
        end
    end
`endif

    initial begin
        set_cfg(0, 10, 5);
        set_cfg(1, 0, 0);
        set_cfg(2, 100, 20);
        set_cfg(3, 50, 5);
        #140 chk_idle("in reset");
        #160 reset = 1'b1;
        repeat (10) @(negedge clk);
        chk_idle("after reset");

        // ch0 d=10 w=5 and ch1 d=0 w=0 triggered together
        t = cyc + 1;
        evr_trigger[1:0] = 2'b11;
        exp_q.push_back('{0, t + 14, 5});
        exp_q.push_back('{1, t + 4, 1});
        wait_to(t + 3);  chk("busy0 before accept", int'(busy[0]), 0);
        wait_to(t + 4);  chk("busy0 first", int'(busy[0]), 1);
        wait_to(t + 18); chk("busy0 last", int'(busy[0]), 1);
        wait_to(t + 19); chk("busy0 after", int'(busy[0]), 0);
        evr_trigger[1:0] = 2'b00;
        wait_to(t + 30);

        // ch2 overrun: second edge at cycle 50 is ignored
        t = cyc + 1;
        evr_trigger[2] = 1'b1;
        exp_q.push_back('{2, t + 104, 20});
        wait_to(t + 20);  evr_trigger[2] = 1'b0;
        wait_to(t + 49);  evr_trigger[2] = 1'b1;
        wait_to(t + 52);  chk("ovr2 before edge", int'(overrun[2]), 0);
        wait_to(t + 53);  chk("ovr2 set", int'(overrun[2]), 1);
        chk("busy2 during overrun", int'(busy[2]), 1);
        wait_to(t + 130); chk("ovr2 sticky", int'(overrun[2]), 1);
        clear_overrun[2] = 1'b1;
        @(negedge clk);
        clear_overrun[2] = 1'b0;
        chk("ovr2 cleared", int'(overrun[2]), 0);
        evr_trigger[2] = 1'b0;
        repeat (5) @(negedge clk);

        // ch2 set and clear in the same cycle: set wins
        t = cyc + 1;
        evr_trigger[2] = 1'b1;
        exp_q.push_back('{2, t + 104, 20});
        wait_to(t + 10);  evr_trigger[2] = 1'b0;
        wait_to(t + 29);  evr_trigger[2] = 1'b1;
        wait_to(t + 32);  clear_overrun[2] = 1'b1;
        wait_to(t + 33);  clear_overrun[2] = 1'b0;
        chk("ovr2 set beats clear", int'(overrun[2]), 1);
        wait_to(t + 40);  chk("ovr2 held", int'(overrun[2]), 1);
        wait_to(t + 130);
        evr_trigger[2] = 1'b0;
        clear_overrun[2] = 1'b1;
        @(negedge clk);
        clear_overrun[2] = 1'b0;

        // ch3 d=50 aborted by enable drop; edges while disabled are discarded
        t = cyc + 1;
        evr_trigger[3] = 1'b1;
        wait_to(t + 29);  chk("busy3 before disable", int'(busy[3]), 1);
        enable = 1'b0;
        wait_to(t + 31);  chk("busy3 disabled", int'(busy[3]), 0);
        chk("psc3 disabled", int'(psc_output[3]), 0);
        wait_to(t + 32);  evr_trigger[0] = 1'b1;
        wait_to(t + 40);  enable = 1'b1;
        wait_to(t + 120);
        chk("busy after re-enable", int'(busy), 0);
        chk("overrun after re-enable", int'(overrun), 0);
        evr_trigger[3] = 1'b0;
        evr_trigger[0] = 1'b0;
        repeat (5) @(negedge clk);

        // ch1 and ch3 fire in the same cycle
        set_cfg(3, 0, 0);
        t = cyc + 1;
        evr_trigger[1] = 1'b1;
        evr_trigger[3] = 1'b1;
        exp_q.push_back('{1, t + 4, 1});
        exp_q.push_back('{3, t + 4, 1});
`ifdef PSC_TRIGGER_TX_FRAME_EN
        exp_f.push_back('{10'b1_00000001_0, -1});
        exp_f.push_back('{10'b1_00000011_0, 40});
`endif
        wait_to(t + 110);
        evr_trigger[1] = 1'b0;
        evr_trigger[3] = 1'b0;
        repeat (5) @(negedge clk);

        // reset asserted mid-operation forces the line idle at once
        t = cyc + 1;
        evr_trigger[1] = 1'b1;
        exp_q.push_back('{1, t + 4, 1});
`ifdef PSC_TRIGGER_TX_FRAME_EN
        for (int k = 0; k < 40 && tx_output; k++) @(negedge clk);
        chk("tx frame started", int'(tx_output), 0);
        repeat (10) @(negedge clk);
`else
        wait_to(t + 20);
`endif
        #5 reset = 1'b0;
        #1 chk_idle("async reset");
        #50 reset = 1'b1;
        evr_trigger[1] = 1'b0;
        repeat (5) @(negedge clk);

        chk("pulses outstanding", exp_q.size(), 0);
`ifdef PSC_TRIGGER_TX_FRAME_EN
        chk("frames outstanding", exp_f.size(), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
